// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / debug) arbiter for the shared memory: sequences IDLE->SETUP->ACCESS->DONE
// and owns the memory strobes. Define ARB_ROUND_ROBIN_EN for round-robin arbitration on contention.
module mem_bus_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_done_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_ce_o,
    output logic              mem_oe_o,
    output logic              mem_r_o,
    output logic              mem_w_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               any_req_s;
    logic               winner_s;

    assign any_req_s = cpu_req_i | dbg_req_i;

    // Winner: 0 = CPU, 1 = debug. Only meaningful while any_req_s is high.
`ifdef ARB_ROUND_ROBIN_EN
    assign winner_s = (cpu_req_i & dbg_req_i) ? ~last_owner_q : ~cpu_req_i;
`else
    assign winner_s = ~cpu_req_i;
`endif

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            rdata_q      <= {DATA_W{1'b0}};
            cnt_q        <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic of the access sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = DONE;
                end else begin
                    state_d = ACCESS;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching, access countdown and read capture
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    owner_d = winner_s;
                    if (winner_s) begin
                        we_d    = dbg_we_i;
                        addr_d  = dbg_addr_i;
                        wdata_d = dbg_wdata_i;
                    end else begin
                        we_d    = cpu_we_i;
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_wdata_i;
                    end
                end else begin
                    owner_d = owner_q;
                end
            end
            SETUP: cnt_d = CNT_INIT;
            ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    last_owner_d = owner_q;
            default: cnt_d = CNT_ZERO;
        endcase
    end

    // Handshake and strobe decode from state/owner/direction
    always_comb begin
        cpu_gnt_o  = 1'b0;
        cpu_done_o = 1'b0;
        dbg_gnt_o  = 1'b0;
        dbg_done_o = 1'b0;
        mem_ce_o   = 1'b0;
        mem_oe_o   = 1'b0;
        mem_r_o    = 1'b0;
        mem_w_o    = 1'b0;
        case (state_q)
            IDLE: mem_ce_o = 1'b0;
            SETUP: begin
                cpu_gnt_o = ~owner_q;
                dbg_gnt_o = owner_q;
                mem_ce_o  = 1'b1;
            end
            ACCESS: begin
                mem_ce_o = 1'b1;
                if (we_q) begin
                    mem_w_o = 1'b1;
                end else begin
                    mem_oe_o = 1'b1;
                    mem_r_o  = 1'b1;
                end
            end
            DONE: begin
                cpu_done_o = ~owner_q;
                dbg_done_o = owner_q;
            end
            default: mem_ce_o = 1'b0;
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; honours ARB_ROUND_ROBIN_EN for the contention order.
// Extra instances with ACCESS_CYCLES=1 and 15 share the inputs and are checked in the latency test.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, dbg_addr;
    logic [7:0]  cpu_wdata, dbg_wdata, mem_rdata;

    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_ce, mem_oe, mem_r, mem_w;
    logic [7:0]  rdata, mem_wdata;
    logic [15:0] mem_addr;

    logic        d1_cg, d1_cd, d1_dg, d1_dd, d1_ce, d1_oe, d1_r, d1_w;
    logic [7:0]  d1_rd, d1_wd;
    logic [15:0] d1_a;
    logic        d15_cg, d15_cd, d15_dg, d15_dd, d15_ce, d15_oe, d15_r, d15_w;
    logic [7:0]  d15_rd, d15_wd;
    logic [15:0] d15_a;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_done_o(cpu_done),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_done_o(dbg_done), .rdata_o(rdata),
        .mem_ce_o(mem_ce), .mem_oe_o(mem_oe), .mem_r_o(mem_r), .mem_w_o(mem_w),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_bus_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(d1_cg), .cpu_done_o(d1_cd),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(d1_dg), .dbg_done_o(d1_dd), .rdata_o(d1_rd),
        .mem_ce_o(d1_ce), .mem_oe_o(d1_oe), .mem_r_o(d1_r), .mem_w_o(d1_w),
        .mem_addr_o(d1_a), .mem_wdata_o(d1_wd), .mem_rdata_i(mem_rdata)
    );

    mem_bus_arbiter #(.ACCESS_CYCLES(15)) dut15 (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(d15_cg), .cpu_done_o(d15_cd),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(d15_dg), .dbg_done_o(d15_dd), .rdata_o(d15_rd),
        .mem_ce_o(d15_ce), .mem_oe_o(d15_oe), .mem_r_o(d15_r), .mem_w_o(d15_w),
        .mem_addr_o(d15_a), .mem_wdata_o(d15_wd), .mem_rdata_i(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic is_dbg, input logic we, input logic [15:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd);
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        step();
        check_eq("acc_gnt", {30'd0, cpu_gnt, dbg_gnt}, is_dbg ? 32'd1 : 32'd2);
        check_eq("acc_setup_strb", {28'd0, mem_ce, mem_oe, mem_r, mem_w}, 32'h8);
        cpu_req = 1'b0; dbg_req = 1'b0;
        cpu_addr = ~addr; dbg_addr = ~addr; cpu_wdata = ~wd; dbg_wdata = ~wd;
        cpu_we = ~we; dbg_we = ~we;
        for (int c = 0; c < 2; c++) begin
            step();
            check_eq("acc_strb", {28'd0, mem_ce, mem_oe, mem_r, mem_w},
                     {28'd0, 1'b1, ~we, ~we, we});
            check_eq("acc_addr", {16'd0, mem_addr}, {16'd0, addr});
            check_eq("acc_hs_quiet", {28'd0, cpu_gnt, dbg_gnt, cpu_done, dbg_done}, 32'd0);
            if (we) check_eq("acc_wdata", {24'd0, mem_wdata}, {24'd0, wd});
        end
        step();
        check_eq("acc_done", {30'd0, cpu_done, dbg_done}, is_dbg ? 32'd1 : 32'd2);
        check_eq("acc_done_strb", {28'd0, mem_ce, mem_oe, mem_r, mem_w}, 32'd0);
        check_eq("acc_rdata", {24'd0, rdata}, {24'd0, exp_rd});
        step();
        check_eq("acc_idle", {26'd0, cpu_gnt, dbg_gnt, cpu_done, dbg_done, mem_ce, mem_w}, 32'd0);
    endtask

    initial begin
        int       ng, both, dn;
        int       gcyc [3];
        logic [2:0] who;
        int       t0, t1, t15, g1, g15, r1, r15, ce1, ce15, bad;

        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h1234; dbg_wdata = 8'h3C;
        mem_rdata = 8'h5A;

        // Reset with both requests pending
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_hs_strb", {24'd0, cpu_gnt, cpu_done, dbg_gnt, dbg_done,
                                     mem_ce, mem_oe, mem_r, mem_w}, 32'd0);
            check_eq("rst_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
            check_eq("rst_rdata", {24'd0, rdata}, 32'd0);
        end
        rst_n = 1'b1;
        step();
        check_eq("rst_first_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'd2);
        cpu_req = 1'b0; dbg_req = 1'b0;
        step(); step(); step();
        check_eq("rst_first_done", {30'd0, cpu_done, dbg_done}, 32'd2);
        check_eq("rst_first_rdata", {24'd0, rdata}, 32'h5A);
        step();

        // CPU read, then debug write leaves rdata untouched
        mem_rdata = 8'hA5;
        do_access(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5);
        mem_rdata = 8'h11;
        do_access(1'b1, 1'b1, 16'h1234, 8'h3C, 8'hA5);
        mem_rdata = 8'hA5;

        // Contention: both requests held for three grants
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0200;
        ng = 0; both = 0; who = 3'b000;
        for (int k = 1; k <= 25 && ng < 3; k++) begin
            step();
            if (cpu_gnt && dbg_gnt) both++;
            if (cpu_gnt || dbg_gnt) begin
                who[ng] = dbg_gnt;
                gcyc[ng] = k;
                ng++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_eq("cont_ngrants", ng, 3);
        check_eq("cont_exclusive", both, 0);
`ifdef ARB_ROUND_ROBIN_EN
        check_eq("cont_order", {29'd0, who}, 32'b010);
`else
        check_eq("cont_order", {29'd0, who}, 32'b000);
`endif
        check_eq("cont_gcyc0", gcyc[0], 1);
        check_eq("cont_gcyc1", gcyc[1], 6);
        check_eq("cont_gcyc2", gcyc[2], 11);
        check_eq("cont_idle", {30'd0, mem_ce, cpu_gnt | dbg_gnt}, 32'd0);

        // Reset during the first ACCESS cycle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        step();
        cpu_req = 1'b0;
        step();
        check_eq("mid_pre_strb", {28'd0, mem_ce, mem_oe, mem_r, mem_w}, 32'hE);
        rst_n = 1'b0;
        step();
        check_eq("mid_strb", {28'd0, mem_ce, mem_oe, mem_r, mem_w}, 32'd0);
        check_eq("mid_hs", {28'd0, cpu_gnt, cpu_done, dbg_gnt, dbg_done}, 32'd0);
        check_eq("mid_rdata", {24'd0, rdata}, 32'd0);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            dn += int'(cpu_done | dbg_done);
        end
        check_eq("mid_no_done", dn, 0);

        // Latency for ACCESS_CYCLES = 2, 1, 15
        mem_rdata = 8'h96;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0ABC; cpu_wdata = 8'h77;
        t0 = 0; t1 = 0; t15 = 0; g1 = 0; g15 = 0; r1 = 0; r15 = 0; ce1 = 0; ce15 = 0; bad = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (cpu_gnt) cpu_req = 1'b0;
            if (cpu_done && t0 == 0) t0 = k;
            if (d1_cd && t1 == 0) t1 = k;
            if (d15_cd && t15 == 0) t15 = k;
            if (d1_cg && g1 == 0) g1 = k;
            if (d15_cg && g15 == 0) g15 = k;
            r1 += int'(d1_r);
            r15 += int'(d15_r);
            ce1 += int'(d1_ce);
            ce15 += int'(d15_ce);
            bad += int'(d1_dg | d1_dd | d1_w | (d1_oe ^ d1_r));
            bad += int'(d15_dg | d15_dd | d15_w | (d15_oe ^ d15_r));
        end
        check_eq("lat_ac2", t0, 4);
        check_eq("lat_ac1", t1, 3);
        check_eq("lat_ac15", t15, 17);
        check_eq("gnt_ac1", g1, 1);
        check_eq("gnt_ac15", g15, 1);
        check_eq("rcyc_ac1", r1, 1);
        check_eq("rcyc_ac15", r15, 15);
        check_eq("cecyc_ac1", ce1, 2);
        check_eq("cecyc_ac15", ce15, 16);
        check_eq("strb_rules", bad, 0);
        check_eq("rdata_ac1", {24'd0, d1_rd}, 32'h96);
        check_eq("rdata_ac15", {24'd0, d15_rd}, 32'h96);
        check_eq("rdata_ac2", {24'd0, rdata}, 32'h96);
        check_eq("addr_ac1", {16'd0, d1_a}, 32'h0ABC);
        check_eq("addr_ac15", {16'd0, d15_a}, 32'h0ABC);
        check_eq("wdata_lat", {16'd0, d1_wd, d15_wd}, 32'h7777);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single program/data memory between two requesters:
  - CPU control unit (fetch/operand/store accesses).
  - Debug/loader port (program load, memory inspect).
- Owns the memory strobes (ce/oe/r/w), address and write data.
- Sequences each access through a fixed multi-cycle setup/access/complete cycle.
- Requesters see only a req/gnt/done handshake.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, data bus width.
- ACCESS_CYCLES, 2, cycles strobes stay active in ACCESS; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset; reset is synchronous and active-low.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1=write, 0=read; sampled with grant.
- cpu_addr  in  ADDR_W  CPU address; sampled with grant.
- cpu_wdata  in  DATA_W  CPU write data; sampled with grant.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted.
- cpu_done  out  1  one-cycle pulse: CPU access complete.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same meaning for the debug port.
- dbg_gnt, dbg_done  out  1/1  same meaning for the debug port.
- rdata  out  DATA_W  read data of the last completed read, shared by both requesters.
- mem_ce, mem_oe, mem_r, mem_w  out  1 each  memory strobes.
- mem_addr  out  ADDR_W  latched access address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Registers: state, owner (0=cpu, 1=dbg), last_owner, we_q, addr_q, wdata_q, rdata_q, cycle counter of width clog2(ACCESS_CYCLES+1).
- Reset (rst_n=0 at posedge):
  - state=IDLE, owner=0, last_owner=1, counter=0, addr_q=0, wdata_q=0, rdata_q=0.
  - All gnt/done/mem_* outputs are 0.
- IDLE:
  - If any req is high, the arbiter picks a winner and latches that requester's we/addr/wdata.
  - owner=winner; the winner's gnt goes high next cycle.
  - Next state is SETUP; with no req, stays in IDLE.
- SETUP (1 cycle):
  - gnt of owner=1, mem_ce=1, mem_addr/mem_wdata driven; oe/r/w=0.
  - counter=ACCESS_CYCLES-1; next state ACCESS.
- ACCESS (ACCESS_CYCLES cycles):
  - mem_ce=1.
  - Read: mem_oe=1, mem_r=1.
  - Write: mem_w=1.
  - Counter decrements each cycle. When counter==0: on a read, rdata_q<=mem_rdata; next state DONE.
- DONE (1 cycle):
  - done of owner=1; all strobes 0.
  - last_owner<=owner; next state IDLE.
- Outputs decode combinationally from state/owner/we_q.
  - gnt and done are never high for the non-owner.
  - mem_r and mem_w are never both high.
- Latency: req high in IDLE at cycle 0 → gnt cycle 1 → strobes cycles 2..1+ACCESS_CYCLES → done cycle 2+ACCESS_CYCLES. Default: done at cycle 4.
- Back-to-back: earliest next grant is 2 cycles after done (DONE→IDLE→SETUP).
- Request rules:
  - req is level-sensitive; a req still high in IDLE is treated as a new request.
  - Requesters drop req on gnt, or in the cycle of done.
  - req changes after grant are ignored until IDLE.
- rdata:
  - Holds its value until the next completed read.
  - Writes do not change it.
  - rdata is valid from the DONE cycle onward.
- Arbitration, default build: fixed priority, CPU wins when both req are high; the debug port can starve.
- Reset mid-operation (any state): immediate return to IDLE with reset values; no done pulse for the aborted access; rdata_q cleared.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the winner is the requester that is not last_owner. With a single request, that requester wins regardless.
- Undefined: fixed CPU priority as above; last_owner is still maintained but unused.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both req=1 → all outputs 0, state IDLE. First grant comes 1 cycle after rst_n=1.
- CPU read: cpu_req=1, we=0, addr=0x0010, mem_rdata=0xA5 → cpu_gnt at cycle 1; mem_ce+oe+r high cycles 2-3 with mem_addr=0x0010; cpu_done at cycle 4; rdata=0xA5.
- Debug write: dbg_req=1, we=1, addr=0x1234, wdata=0x3C → mem_w high 2 cycles with mem_wdata=0x3C; dbg_done at cycle 4; rdata unchanged; mem_r never high.
- Contention: both req held high for 3 accesses.
  - Default build: three CPU grants, no dbg_gnt.
  - With ARB_ROUND_ROBIN_EN: grants in order cpu, dbg, cpu.
- Reset mid-access: assert rst_n=0 in the first ACCESS cycle of a CPU read → strobes low next cycle; no cpu_done; rdata=0.
- ACCESS_CYCLES=1 and 15: done arrives exactly 3 and 17 cycles after req.
